// File: rtl/bus_mailbox_if.sv
// bus_mailbox_if: signal bundle for bus_mailbox.
//   CPU side    : cs, rd, wr (level strobes), ar (register address).
//   Stream side : rx_data/rx_valid/rx_ready (agent -> CPU push),
//                 tx_data/tx_valid/tx_ready (CPU -> agent pop), irq.
// The bidirectional data bus dr is a plain inout port of bus_mailbox.
// Modports: slave = mailbox view, master = CPU/agent view.
interface bus_mailbox_if;
   logic       cs;
   logic       rd;
   logic       wr;
   logic [3:0] ar;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       irq;

   modport slave (
      input  cs, rd, wr, ar, rx_data, rx_valid, tx_ready,
      output rx_ready, tx_data, tx_valid, irq
   );

   modport master (
      output cs, rd, wr, ar, rx_data, rx_valid, tx_ready,
      input  rx_ready, tx_data, tx_valid, irq
   );
endinterface

// File: rtl/bus_mailbox.sv
// bus_mailbox: memory-mapped two-FIFO mailbox between the CPU bus and an
// external streaming agent.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   dr   : 8-bit bidirectional data bus, driven only while cs & rd & !wr
//   bus  : bus_mailbox_if.slave (cs/rd/wr/ar strobes, rx/tx streams, irq)
// Registers: 0 DATA, 1 STATUS (W1C bits 4/5), 2 CTRL, 3 COUNT, 4..15 read 0.
// Optional macro BUS_MAILBOX_IRQ_EN: enables the CTRL register and the
// registered irq output; without it CTRL reads 0 and irq is tied low.
module bus_mailbox #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic         clk,
   input  logic         rst,
   inout  wire  [7:0]   dr,
   bus_mailbox_if.slave bus
);
   localparam logic [3:0]       DEPTH_C = 4'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);

   logic [7:0]       rx_mem_r [DEPTH];
   logic [7:0]       tx_mem_r [DEPTH];
   logic [PTR_W-1:0] rx_wp_r, rx_rp_r, tx_wp_r, tx_rp_r;
   logic [3:0]       rx_cnt_r, tx_cnt_r;
   logic [3:0]       rx_cnt_nxt_s, tx_cnt_nxt_s;
   logic             rd_q_r, cs_q_r, wr_q_r;
   logic [3:0]       ar_q_r;
   logic             tx_ovf_r, rx_udf_r;

   logic rx_full_s, rx_nempty_s, tx_full_s, tx_empty_s;
   logic wr_edge_s, pop_edge_s;
   logic rx_push_s, rx_pop_s, tx_push_s, tx_pop_s;
   logic rx_udf_set_s, tx_ovf_set_s, w1c_s;
   logic dr_oe_s;
   logic [7:0] status_s, ctrl_rd_s, rd_data_s;

   assign rx_full_s   = (rx_cnt_r == DEPTH_C);
   assign rx_nempty_s = (rx_cnt_r != 4'd0);
   assign tx_full_s   = (tx_cnt_r == DEPTH_C);
   assign tx_empty_s  = (tx_cnt_r == 4'd0);

   // A write commits only on the first cycle of a wr strobe; a read commits
   // (pops) on the falling edge of rd, so the head stays stable while sampled.
   assign wr_edge_s  = bus.cs & bus.wr & ~wr_q_r;
   assign pop_edge_s = rd_q_r & ~bus.rd & cs_q_r & (ar_q_r == 4'd0);

   assign rx_push_s    = bus.rx_valid & ~rx_full_s;
   assign rx_pop_s     = pop_edge_s & rx_nempty_s;
   assign rx_udf_set_s = pop_edge_s & ~rx_nempty_s;
   assign tx_push_s    = wr_edge_s & (bus.ar == 4'd0) & ~tx_full_s;
   assign tx_ovf_set_s = wr_edge_s & (bus.ar == 4'd0) & tx_full_s;
   assign tx_pop_s     = ~tx_empty_s & bus.tx_ready;
   assign w1c_s        = wr_edge_s & (bus.ar == 4'd1);

   assign bus.rx_ready = ~rx_full_s;
   assign bus.tx_valid = ~tx_empty_s;
   assign bus.tx_data  = tx_empty_s ? 8'h00 : tx_mem_r[tx_rp_r];

   assign status_s = {2'b00, rx_udf_r, tx_ovf_r, tx_full_s, tx_empty_s,
                      rx_full_s, rx_nempty_s};

   // Occupancy update; a push and a pop in the same cycle cancel out.
   always_comb begin
      rx_cnt_nxt_s = rx_cnt_r;
      tx_cnt_nxt_s = tx_cnt_r;
      case ({rx_push_s, rx_pop_s})
         2'b10:   rx_cnt_nxt_s = rx_cnt_r + 4'd1;
         2'b01:   rx_cnt_nxt_s = rx_cnt_r - 4'd1;
         default: rx_cnt_nxt_s = rx_cnt_r;
      endcase
      case ({tx_push_s, tx_pop_s})
         2'b10:   tx_cnt_nxt_s = tx_cnt_r + 4'd1;
         2'b01:   tx_cnt_nxt_s = tx_cnt_r - 4'd1;
         default: tx_cnt_nxt_s = tx_cnt_r;
      endcase
   end

   // Strobe history, FIFO storage/pointers and sticky error flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q_r   <= 1'b0;
         cs_q_r   <= 1'b0;
         wr_q_r   <= 1'b0;
         ar_q_r   <= 4'd0;
         rx_wp_r  <= '0;
         rx_rp_r  <= '0;
         tx_wp_r  <= '0;
         tx_rp_r  <= '0;
         rx_cnt_r <= 4'd0;
         tx_cnt_r <= 4'd0;
         tx_ovf_r <= 1'b0;
         rx_udf_r <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            rx_mem_r[i] <= 8'h00;
            tx_mem_r[i] <= 8'h00;
         end
      end else begin
         rd_q_r   <= bus.rd;
         cs_q_r   <= bus.cs;
         wr_q_r   <= bus.wr;
         ar_q_r   <= bus.ar;
         rx_cnt_r <= rx_cnt_nxt_s;
         tx_cnt_r <= tx_cnt_nxt_s;
         if (rx_push_s) begin
            rx_mem_r[rx_wp_r] <= bus.rx_data;
            rx_wp_r           <= rx_wp_r + PTR_ONE;
         end
         if (rx_pop_s) begin
            rx_rp_r <= rx_rp_r + PTR_ONE;
         end
         if (tx_push_s) begin
            tx_mem_r[tx_wp_r] <= dr;
            tx_wp_r           <= tx_wp_r + PTR_ONE;
         end
         if (tx_pop_s) begin
            tx_rp_r <= tx_rp_r + PTR_ONE;
         end
         // A new event in the same cycle as its W1C keeps the flag set.
         if (tx_ovf_set_s) begin
            tx_ovf_r <= 1'b1;
         end else if (w1c_s & dr[4]) begin
            tx_ovf_r <= 1'b0;
         end
         if (rx_udf_set_s) begin
            rx_udf_r <= 1'b1;
         end else if (w1c_s & dr[5]) begin
            rx_udf_r <= 1'b0;
         end
      end
   end

`ifdef BUS_MAILBOX_IRQ_EN
   logic [1:0] ctrl_r;
   logic       irq_r;

   assign ctrl_rd_s = {6'b000000, ctrl_r};
   assign bus.irq   = irq_r;

   // Interrupt enables and the registered interrupt request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_r <= 2'b00;
         irq_r  <= 1'b0;
      end else begin
         if (wr_edge_s & (bus.ar == 4'd2)) begin
            ctrl_r <= dr[1:0];
         end
         irq_r <= (ctrl_r[0] & rx_nempty_s) | (ctrl_r[1] & tx_empty_s) |
                  tx_ovf_r | rx_udf_r;
      end
   end
`else
   assign ctrl_rd_s = 8'h00;
   assign bus.irq   = 1'b0;
`endif

   // Register read mux; DATA returns 0x00 while the RX FIFO is empty.
   always_comb begin
      rd_data_s = 8'h00;
      case (bus.ar)
         4'd0: begin
            if (rx_nempty_s) begin
               rd_data_s = rx_mem_r[rx_rp_r];
            end else begin
               rd_data_s = 8'h00;
            end
         end
         4'd1:    rd_data_s = status_s;
         4'd2:    rd_data_s = ctrl_rd_s;
         4'd3:    rd_data_s = {tx_cnt_r, rx_cnt_r};
         default: rd_data_s = 8'h00;
      endcase
   end

   assign dr_oe_s = bus.cs & bus.rd & ~bus.wr;
   assign dr      = dr_oe_s ? rd_data_s : 8'hzz;
endmodule
